// File: rtl/rf_scoreboard_pkg.sv
// Shared widths and types for the GR write scoreboard.
// The per-GR counters and the ID/WB ports both take their sizes from here.
package rf_scoreboard_pkg;
  localparam int SB_CNT_W = 2;
  localparam int SB_NREG  = 32;

  typedef logic [4:0] grIdx_t;
endpackage

// File: rtl/rf_scoreboard_if.sv
// Port bundle between ID/WB and the scoreboard.
// The pipeline drives the master side; the scoreboard sits on the slave side.
interface rf_scoreboard_if;
  import rf_scoreboard_pkg::*;

  logic               id_valid;
  logic               id_fire;
  logic               id_rf_we;
  grIdx_t             id_rf_waddr;
  grIdx_t             id_rj;
  logic               id_use_rj;
  grIdx_t             id_rk;
  logic               id_use_rk;
  logic               wb_retire;
  grIdx_t             wb_rf_waddr;
  logic               flush;
  logic               id_stall;
  logic [SB_NREG-1:0] pending_vec;
  logic               sb_err;

  modport master (
    output id_valid, id_fire, id_rf_we, id_rf_waddr, id_rj, id_use_rj,
           id_rk, id_use_rk, wb_retire, wb_rf_waddr, flush,
    input  id_stall, pending_vec, sb_err
  );

  modport slave (
    input  id_valid, id_fire, id_rf_we, id_rf_waddr, id_rj, id_use_rj,
           id_rk, id_use_rk, wb_retire, wb_rf_waddr, flush,
    output id_stall, pending_vec, sb_err
  );
endinterface

// File: rtl/rf_scoreboard_sb_cnt.sv
// Saturating up/down counter for one GR's outstanding writes.
// o_err flags a step that would overflow or underflow; the count holds instead.
module sb_cnt #(
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_inc,
  input  logic             i_dec,
  input  logic             i_clr,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_err
);
  logic [CNT_W-1:0] r_cnt;
  logic             w_up;
  logic             w_down;
  logic             w_full;
  logic             w_empty;

  assign w_up    = i_inc & ~i_dec;
  assign w_down  = i_dec & ~i_inc;
  assign w_full  = (r_cnt == '1);
  assign w_empty = (r_cnt == '0);

  // Clear wins over everything, which also swallows a concurrent retire.
  always_ff @(posedge clk) begin
    if (reset || i_clr) begin
      r_cnt <= '0;
    end else if (w_up && !w_full) begin
      r_cnt <= r_cnt + 1'b1;
    end else if (w_down && !w_empty) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_cnt = r_cnt;
  assign o_err = ~i_clr & ((w_up & w_full) | (w_down & w_empty));
endmodule

// File: rtl/rf_scoreboard.sv
// Pending-write scoreboard beside ID: one counter per GR (r0 untracked), stalls
// ID on a source hazard or a saturated destination, and keeps a sticky error flag.
module rf_scoreboard
  import rf_scoreboard_pkg::*;
#(
  parameter int CNT_W = SB_CNT_W,
  parameter int NREG  = SB_NREG
) (
  input  logic          clk,
  input  logic          reset,
  rf_scoreboard_if.slave sb
);
  logic [CNT_W-1:0] w_cnt [NREG];
  logic [NREG-1:0]  w_pend;
  logic [NREG-1:0]  w_err;
  logic             w_srcHazard;
  logic             w_dstFull;
  logic             w_stall;
  logic             r_sbErr;

  assign w_cnt[0]  = '0;
  assign w_pend[0] = 1'b0;
  assign w_err[0]  = 1'b0;

  for (genvar i = 1; i < NREG; i++) begin : g_cnt
    logic w_inc;
    logic w_dec;

    assign w_inc = sb.id_fire & sb.id_rf_we & (sb.id_rf_waddr == 5'(i));
    assign w_dec = sb.wb_retire & (sb.wb_rf_waddr == 5'(i));

    sb_cnt #(.CNT_W(CNT_W)) u_cnt (
      .clk   (clk),
      .reset (reset),
      .i_inc (w_inc),
      .i_dec (w_dec),
      .i_clr (sb.flush),
      .o_cnt (w_cnt[i]),
      .o_err (w_err[i])
    );

    assign w_pend[i] = (w_cnt[i] != '0);
  end

  // Only current counters feed the stall, so a same-cycle retire never releases it.
  assign w_srcHazard = (sb.id_use_rj & w_pend[sb.id_rj]) | (sb.id_use_rk & w_pend[sb.id_rk]);
  assign w_dstFull   = sb.id_rf_we & (sb.id_rf_waddr != '0) & (w_cnt[sb.id_rf_waddr] == '1);
  assign w_stall     = sb.id_valid & (w_srcHazard | w_dstFull);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sbErr <= 1'b0;
    end else if ((|w_err) || (sb.id_fire && w_stall)) begin
      r_sbErr <= 1'b1;
    end
  end

  assign sb.id_stall    = w_stall;
  assign sb.pending_vec = w_pend;
  assign sb.sb_err      = r_sbErr;
endmodule

// File: tb/tb_rf_scoreboard.sv
// Directed bench for rf_scoreboard: hazard stalls, saturation, r0, flush and
// the sticky error flag, with expected values worked out by hand per step.
module tb_rf_scoreboard;
  import rf_scoreboard_pkg::*;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  rf_scoreboard_if sbIf ();

  rf_scoreboard u_dut (
    .clk   (clk),
    .reset (reset),
    .sb    (sbIf.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(
    input logic valid, input logic fire, input logic we, input grIdx_t waddr,
    input grIdx_t rj, input logic useRj, input grIdx_t rk, input logic useRk,
    input logic retire, input grIdx_t wbAddr, input logic fl
  );
    sbIf.id_valid    = valid;
    sbIf.id_fire     = fire;
    sbIf.id_rf_we    = we;
    sbIf.id_rf_waddr = waddr;
    sbIf.id_rj       = rj;
    sbIf.id_use_rj   = useRj;
    sbIf.id_rk       = rk;
    sbIf.id_use_rk   = useRk;
    sbIf.wb_retire   = retire;
    sbIf.wb_rf_waddr = wbAddr;
    sbIf.flush       = fl;
    #1;
  endtask

  task automatic idle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b1;

    // Reset with a valid instruction reading arbitrary sources.
    applyStimulus(1, 0, 1, 5'd7, 5'd5, 1, 5'd9, 1, 0, 0, 0);
    repeat (3) tick();
    checkOutput("rst_pend", sbIf.pending_vec, 32'h0);
    checkOutput("rst_err", 32'(sbIf.sb_err), 32'h0);
    checkOutput("rst_stall", 32'(sbIf.id_stall), 32'h0);
    reset = 1'b0;
    idle();
    tick();

    // Producer r5 then a dependent reader held until retire.
    applyStimulus(1, 1, 1, 5'd5, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("raw_issue_stall", 32'(sbIf.id_stall), 32'h0);
    tick();
    applyStimulus(1, 0, 0, 0, 5'd5, 1, 0, 0, 0, 0, 0);
    checkOutput("raw_stall", 32'(sbIf.id_stall), 32'h1);
    checkOutput("raw_pend", sbIf.pending_vec, 32'h0000_0020);
    tick();
    applyStimulus(1, 0, 0, 0, 5'd5, 1, 0, 0, 1, 5'd5, 0);
    checkOutput("raw_nobypass", 32'(sbIf.id_stall), 32'h1);
    tick();
    applyStimulus(1, 0, 0, 0, 5'd5, 1, 0, 0, 0, 0, 0);
    checkOutput("raw_release", 32'(sbIf.id_stall), 32'h0);
    checkOutput("raw_pend_clr", sbIf.pending_vec, 32'h0);
    applyStimulus(1, 1, 0, 0, 5'd5, 1, 0, 0, 0, 0, 0);
    tick();

    // Three writers of r7 saturate the counter.
    applyStimulus(1, 1, 1, 5'd7, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) tick();
    applyStimulus(1, 0, 1, 5'd7, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("sat_pend", sbIf.pending_vec, 32'h0000_0080);
    checkOutput("sat_stall", 32'(sbIf.id_stall), 32'h1);
    applyStimulus(1, 0, 1, 5'd7, 0, 0, 0, 0, 1, 5'd7, 0);
    checkOutput("sat_retire_same", 32'(sbIf.id_stall), 32'h1);
    tick();
    applyStimulus(1, 0, 1, 5'd7, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("sat_release", 32'(sbIf.id_stall), 32'h0);
    // Fire and retire together keep cnt[7]=2; one more fire must saturate it.
    applyStimulus(1, 1, 1, 5'd7, 0, 0, 0, 0, 1, 5'd7, 0);
    tick();
    applyStimulus(1, 0, 1, 5'd7, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("inc_dec_hold", 32'(sbIf.id_stall), 32'h0);
    applyStimulus(1, 1, 1, 5'd7, 0, 0, 0, 0, 0, 0, 0);
    tick();
    applyStimulus(1, 0, 1, 5'd7, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("inc_dec_resat", 32'(sbIf.id_stall), 32'h1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 5'd7, 0);
    repeat (3) tick();
    idle();
    checkOutput("sat_drain_pend", sbIf.pending_vec, 32'h0);
    checkOutput("sat_drain_err", 32'(sbIf.sb_err), 32'h0);

    // r0 is never tracked, written, read or retired.
    applyStimulus(1, 1, 1, 5'd0, 5'd0, 1, 5'd0, 1, 0, 0, 0);
    checkOutput("r0_stall_a", 32'(sbIf.id_stall), 32'h0);
    tick();
    applyStimulus(1, 0, 1, 5'd0, 5'd0, 1, 5'd0, 1, 1, 5'd0, 0);
    checkOutput("r0_pend", sbIf.pending_vec, 32'h0);
    checkOutput("r0_stall_b", 32'(sbIf.id_stall), 32'h0);
    tick();
    idle();
    checkOutput("r0_err", 32'(sbIf.sb_err), 32'h0);

    // r3, r9 and a self-dependent r6 pending, then flush with a retire of r3.
    applyStimulus(1, 1, 1, 5'd3, 0, 0, 0, 0, 0, 0, 0);
    tick();
    applyStimulus(1, 1, 1, 5'd9, 0, 0, 0, 0, 0, 0, 0);
    tick();
    applyStimulus(1, 1, 1, 5'd6, 5'd6, 1, 0, 0, 0, 0, 0);
    checkOutput("self_src_stall", 32'(sbIf.id_stall), 32'h0);
    tick();
    idle();
    checkOutput("flush_pre_pend", sbIf.pending_vec, 32'h0000_0248);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 5'd3, 1);
    tick();
    idle();
    checkOutput("flush_pend", sbIf.pending_vec, 32'h0);
    checkOutput("flush_err", 32'(sbIf.sb_err), 32'h0);

    // Underflow on r4 sets a sticky error.
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 5'd4, 0);
    tick();
    idle();
    checkOutput("uflow_err", 32'(sbIf.sb_err), 32'h1);
    checkOutput("uflow_cnt", sbIf.pending_vec, 32'h0);
    repeat (2) tick();
    checkOutput("uflow_sticky", 32'(sbIf.sb_err), 32'h1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checkOutput("uflow_rst", 32'(sbIf.sb_err), 32'h0);

    // Firing a stalled reader sets the error; the write update is still applied.
    applyStimulus(1, 1, 1, 5'd5, 0, 0, 0, 0, 0, 0, 0);
    tick();
    applyStimulus(1, 1, 1, 5'd8, 5'd5, 1, 0, 0, 0, 0, 0);
    tick();
    idle();
    checkOutput("stallfire_err", 32'(sbIf.sb_err), 32'h1);
    checkOutput("stallfire_pend", sbIf.pending_vec, 32'h0000_0120);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checkOutput("midrst_pend", sbIf.pending_vec, 32'h0);
    checkOutput("midrst_err", 32'(sbIf.sb_err), 32'h0);

    // Forced fire into a saturated r2 holds the counter at max.
    applyStimulus(1, 1, 1, 5'd2, 0, 0, 0, 0, 0, 0, 0);
    repeat (4) tick();
    idle();
    checkOutput("ovf_err", 32'(sbIf.sb_err), 32'h1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 5'd2, 0);
    repeat (2) tick();
    idle();
    checkOutput("ovf_hold", sbIf.pending_vec, 32'h0000_0004);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
